// File: rtl/blink_pkg.sv
// Shared constants for the LED blink generator and its receive-side monitor.
package blink_pkg;

    // Nominal phase lengths used by the generator; the monitor expects the same by default.
    localparam int unsigned BLINK_ON_TIME  = 25_000_000;
    localparam int unsigned BLINK_OFF_TIME = 25_000_000;

    // Monitor state encoding.
    typedef logic [1:0] mon_state_t;
    localparam logic [1:0] WAIT_EDGE = 2'd0;  // current phase length unknown
    localparam logic [1:0] FIRST     = 2'd1;  // phase in progress has a known start
    localparam logic [1:0] RUN       = 2'd2;  // measuring steadily

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle delayed copy
// used to detect rising and falling transitions of the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s_prev;

    // Shift the input through the synchronizer and keep the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            meta   <= sig_in;
            s      <= meta;
            s_prev <= s;
        end
    end

    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

endmodule

// File: rtl/blink_monitor.sv
// Measures the high and low phase lengths of an asynchronous blink waveform,
// reports each completed low+high pair and checks it against expected lengths.
// Flags a stuck input when no transition is seen for TIMEOUT cycles.
//
// Output protocol: meas_valid is a single-cycle strobe with no back-pressure.
// on_time, off_time and match change only in the cycle meas_valid is high and
// hold their values otherwise; a consumer that needs each report must sample
// them in that cycle.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned EXP_ON  = BLINK_ON_TIME,
    parameter int unsigned EXP_OFF = BLINK_OFF_TIME,
    parameter int unsigned TOL     = 1000,
    parameter int unsigned TIMEOUT = 100_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic         meas_valid,
    output logic [W-1:0] on_time,
    output logic [W-1:0] off_time,
    output logic         match,
    output logic         stuck,
    output logic [15:0]  meas_count,
    output logic [1:0]   dbg_state
);

    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] CNT_MAX   = '1;
    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
    localparam logic [W:0]   EXP_ON_X  = (W+1)'(EXP_ON);
    localparam logic [W:0]   EXP_OFF_X = (W+1)'(EXP_OFF);
    localparam logic [W:0]   TOL_X     = (W+1)'(TOL);

    logic         s_level;
    logic         rise;
    logic         fall;
    logic         edge_hit;
    logic         timeout_hit;
    logic         report;
    logic [W-1:0] cnt;
    logic [W-1:0] off_len;
    logic         off_valid;
    mon_state_t   state;
    logic [W:0]   on_ext;
    logic [W:0]   off_ext;
    logic [W:0]   diff_on;
    logic [W:0]   diff_off;
    logic         match_next;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .s      (s_level),
        .rise   (rise),
        .fall   (fall)
    );

    // On an edge cycle the synchronized level tells the direction: high means rise.
    assign edge_hit    = rise | fall;
    assign timeout_hit = !edge_hit && (cnt == TIMEOUT_W);
    // A falling edge closes a high phase; it is reportable only if its low phase was captured.
    assign report      = edge_hit && !s_level && (state == RUN) && off_valid;
    assign dbg_state   = state;

    // Absolute deviation of the closing phase pair from the expected lengths, one bit wider than W.
    always_comb begin
        on_ext     = {1'b0, cnt};
        off_ext    = {1'b0, off_len};
        diff_on    = (on_ext >= EXP_ON_X) ? (on_ext - EXP_ON_X) : (EXP_ON_X - on_ext);
        diff_off   = (off_ext >= EXP_OFF_X) ? (off_ext - EXP_OFF_X) : (EXP_OFF_X - off_ext);
        match_next = (diff_on <= TOL_X) && (diff_off <= TOL_X);
    end

    // Phase length counter: reloads to 1 on every edge, otherwise counts up and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_hit) begin
            cnt <= ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + ONE;
        end
    end

    // Phase tracking state machine, low-phase capture and stuck detection; an edge beats a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_EDGE;
            off_len   <= '0;
            off_valid <= 1'b0;
            stuck     <= 1'b0;
        end else if (edge_hit) begin
            stuck <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    state     <= FIRST;
                    off_valid <= 1'b0;
                end
                FIRST: begin
                    state <= RUN;
                    if (s_level) begin
                        off_len   <= cnt;
                        off_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (s_level) begin
                        off_len   <= cnt;
                        off_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= WAIT_EDGE;
                    off_valid <= 1'b0;
                end
            endcase
        end else if (timeout_hit) begin
            stuck     <= 1'b1;
            state     <= WAIT_EDGE;
            off_valid <= 1'b0;
        end
    end

    // Registered measurement report and pulse counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            on_time    <= '0;
            off_time   <= '0;
            match      <= 1'b0;
            meas_count <= 16'd0;
        end else begin
            meas_valid <= report;
            if (report) begin
                on_time    <= cnt;
                off_time   <= off_len;
                match      <= match_next;
                meas_count <= meas_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/blink_monitor.md
Name: blink_monitor

Overview:
- Receive-side counterpart of the LED blink generator: observes an asynchronous on/off waveform and measures each high (ON) and low (OFF) phase length in clk cycles.
- Reports each completed OFF+ON pair and checks it against expected ON/OFF lengths within a tolerance.
- Flags a stuck input when no edge arrives within a timeout.
- Sits beside the blink generator in lab top-levels, or on a board input, for self-check.

Parameters:
- W, 32: width of the phase counters and of on_time/off_time.
- EXP_ON, 25000000: expected ON-phase length in cycles.
- EXP_OFF, 25000000: expected OFF-phase length in cycles.
- TOL, 1000: allowed absolute deviation per phase, in cycles.
- TIMEOUT, 100000000: cycles without an edge before stuck asserts. Must be ≤ 2^W-1 and > 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  monitored waveform, asynchronous to clk.
- meas_valid  out  1  one-cycle pulse; on_time/off_time/match updated this cycle.
- on_time  out  W  length of the last complete high phase.
- off_time  out  W  length of the low phase immediately preceding that high phase.
- match  out  1  on_time and off_time both within TOL of EXP_ON/EXP_OFF.
- stuck  out  1  level: no sig_in edge for TIMEOUT cycles.
- meas_count  out  16  number of meas_valid pulses since reset; wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release to clk): all outputs 0, synchronizer flops 0, cnt=0, off_len=0, state=WAIT_EDGE.
- Synchronizer: 2 flops produce s; s_prev is s delayed one cycle. An edge means s != s_prev; rise = s&!s_prev; fall = !s&s_prev.
- Phase counter cnt: on an edge cycle cnt←1; otherwise cnt←cnt+1, saturating at 2^W-1. On an edge cycle, cnt before update is the length of the phase that just ended.
- The spurious edge caused by sig_in being high at reset release is absorbed by WAIT_EDGE.
- State machine:
  - WAIT_EDGE: the current phase length is unknown. Any edge → FIRST.
  - FIRST: the phase in progress is complete-bounded.
    - rise: off_len←cnt, go to RUN.
    - fall: go to RUN with no off_len captured. The next rise captures one.
  - RUN:
    - rise: off_len←cnt.
    - fall, and off_len was captured since entering FIRST: on_time←cnt, off_time←off_len, match updated, meas_valid=1 next cycle, meas_count+1.
- match = (|on - EXP_ON| ≤ TOL) && (|off - EXP_OFF| ≤ TOL). Compute with W+1-bit unsigned difference, no overflow.
- Timeout: when cnt reaches TIMEOUT with no edge, stuck←1 and state←WAIT_EDGE; off_len is invalidated.
  - The next edge clears stuck on the following cycle and moves to FIRST.
  - That edge's saturated phase is never reported.
- Latency: a sig_in transition first sampled at clk edge k gives an edge cycle at k+2. meas_valid, on_time, off_time and match are registered and visible at k+3. meas_valid is high exactly one cycle.
- on_time, off_time and match hold their values between pulses.
- Simultaneous timeout and edge in the same cycle: the edge wins. stuck is not set, and the counter reloads to 1.
- Glitches shorter than one clk may be missed. A 1-cycle phase is measured as length 1.
- Reset mid-measurement: everything is discarded. The first report requires a full low and high phase after reset.

Decomposition:
- Shared package blink_pkg:
  - constants BLINK_ON_TIME / BLINK_OFF_TIME, also used by the generator, as defaults for EXP_ON/EXP_OFF;
  - state encoding WAIT_EDGE=2'd0, FIRST=2'd1, RUN=2'd2.
- Sub-module sync_edge_det: 2-flop synchronizer plus s_prev register, outputs s, rise, fall; async active-low reset to 0.

Test Plan (override W=8, EXP_ON=10, EXP_OFF=5, TOL=1, TIMEOUT=40):
- sig_in repeating 5 cycles low / 10 high, from reset → first meas_valid after the first full low+high pair, on_time=10, off_time=5, match=1; then one pulse per period, meas_count increments by 1 each, pulse 3 cycles after the falling sig_in edge.
- Pattern 7 low / 12 high → on_time=12, off_time=7, match=0. Boundary 6 low / 9 high (exact tolerance) → match=1.
- sig_in high at reset release, then 5 low / 10 high → no report for the partial first high phase; first report on_time=10, off_time=5.
- sig_in held low 45 cycles → stuck=1 at cnt=40. Then rise → stuck=0; no meas_valid until a full subsequent low+high is seen.
- rst_n pulsed low mid high-phase → all outputs 0 immediately (async), meas_count=0; measurement restarts cleanly.
- Alternating 1-cycle-wide phases (sig_in toggles every clk) → on_time=1, off_time=1, meas_valid every 2 cycles, stuck stays 0.
